mem_port_arbiter: RTL

- Shares one single-ported unified instruction/data memory between the pipeline's fetch stage (instruction port) and memory stage (data port).
- A small FSM grants one requester at a time and drives a req/ack memory handshake.
- Stalls are returned to the hazard logic as stall_if and stall_mem.
- Data port has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and the data port.
// Data wins by default; a saturating starvation counter forces a fetch grant periodically.
module mem_port_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ready,

  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,

  output logic             m_req,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata,
  input  logic             m_ack,

  output logic             stall_if,
  output logic             stall_mem
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIServ, StDServ} state_e;

  state_e           state_q, state_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic             grant_data, grant_instr;

  // Fetch only loses to data while the starvation budget is not yet spent.
  assign grant_data  = d_req && (!i_req || (starve_cnt_q < StarveLimit));
  assign grant_instr = i_req && !grant_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= 4'd0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d   = StDServ;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_req) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != StarveLimit) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (grant_instr) begin
          state_d      = StIServ;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
          m_wdata_d    = '0;
          starve_cnt_d = 4'd0;
        end else begin
          m_req_d      = 1'b0;
          starve_cnt_d = 4'd0;
        end
      end
      StIServ, StDServ: begin
        // Returning to idle for one cycle lets a requester drop req after ready.
        if (m_ack) begin
          state_d = StIdle;
          m_req_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    i_ready = m_ack && (state_q == StIServ);
    d_ready = m_ack && (state_q == StDServ);
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule
